// File: rtl/joust2_audio_pkg.sv
// joust2_audio_pkg
//   Shared definitions for the Joust 2 audio mixer: width constants, the mix
//   FSM state encoding, the source-kind selector for the gain-term block and
//   the output saturation helpers.
package joust2_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;
  localparam int ACC_W    = 20;
  localparam int TERM_W   = 17;

  localparam logic [GAIN_W-1:0] UNITY_GAIN = 4'd8;

  localparam logic signed [ACC_W-1:0] SAMPLE_MAX = 20'sd32767;
  localparam logic signed [ACC_W-1:0] SAMPLE_MIN = -20'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC0 = 3'd1,
    ST_ACC1 = 3'd2,
    ST_ACC2 = 3'd3,
    ST_ACC3 = 3'd4,
    ST_SAT  = 3'd5,
    ST_OUT  = 3'd6
  } mix_state_e;

  // Offset-binary sources (DAC, speech) need their MSB flipped; FM is already signed.
  typedef enum logic [1:0] {
    SRC_DAC    = 2'd0,
    SRC_SPEECH = 2'd1,
    SRC_FM     = 2'd2
  } src_kind_e;

  function automatic logic sample_out_of_range(input logic signed [ACC_W-1:0] acc);
    return (acc > SAMPLE_MAX) || (acc < SAMPLE_MIN);
  endfunction

  function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic signed [ACC_W-1:0] acc);
    if (acc > SAMPLE_MAX) begin
      return 16'h7FFF;
    end else if (acc < SAMPLE_MIN) begin
      return 16'h8000;
    end else begin
      return 16'(acc);
    end
  endfunction

endpackage

// File: rtl/joust2_audio_mix_gain.sv
// joust2_gain_term
//   Converts one audio source to signed 16-bit, multiplies by its 4-bit
//   unsigned gain (8 = unity) and arithmetic-shifts right by 3.
//   Ports:
//     i_raw   16  source sample; DAC bytes arrive in the upper byte (low byte 0)
//     i_gain   4  unsigned gain
//     o_term  17  signed gained term
module joust2_gain_term
  import joust2_audio_pkg::*;
#(
  parameter src_kind_e KIND = SRC_FM
) (
  input  logic [SAMPLE_W-1:0]      i_raw,
  input  logic [GAIN_W-1:0]        i_gain,
  output logic signed [TERM_W-1:0] o_term
);

  logic signed [SAMPLE_W-1:0] w_sample;
  logic signed [ACC_W-1:0]    w_sample_ext;
  logic signed [ACC_W-1:0]    w_gain_ext;
  logic signed [ACC_W-1:0]    w_prod;

  // Sign conversion: a DAC byte placed in the upper half behaves exactly like
  // an offset-binary 16-bit speech sample, so both share the MSB flip.
  always_comb begin
    w_sample = i_raw;
    case (KIND)
      SRC_DAC, SRC_SPEECH: w_sample = {~i_raw[SAMPLE_W-1], i_raw[SAMPLE_W-2:0]};
      SRC_FM:              w_sample = i_raw;
      default:             w_sample = i_raw;
    endcase
  end

  // |sample * 15| < 2^19, so a 20-bit signed product cannot overflow.
  assign w_sample_ext = {{(ACC_W-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};
  assign w_gain_ext   = {{(ACC_W-GAIN_W){1'b0}}, i_gain};
  assign w_prod       = w_sample_ext * w_gain_ext;
  assign o_term       = TERM_W'(w_prod >>> 3);

endmodule

// File: rtl/joust2_audio_mix.sv
// joust2_audio_mix
//   Sequential stereo mixer: on a sample strobe it snapshots two DAC sources,
//   speech and the YM2151 left/right outputs with their gains, accumulates the
//   gained terms over four cycles, saturates to 16 bits and presents the result.
//   Ports:
//     i_clk_sys, i_reset             clock, synchronous active-high reset
//     i_ce_sample                    one-cycle strobe starting a mix
//     i_mute                         zero the mixed output (captured with inputs)
//     i_audio_1/2 (8), i_speech (16) offset-binary sources
//     i_ym2151_left/right (16)       signed FM sources
//     i_gain_dac/speech/fm (4)       gains, 8 = unity
//     i_clr_flags                    clears clip/overrun (a set event wins)
//     o_audio_l/r (16)               signed mixed samples
//     o_sample_valid                 one-cycle pulse on output update
//     o_busy                         mix in progress
//     o_clip, o_overrun              sticky status flags
module joust2_audio_mix
  import joust2_audio_pkg::*;
(
  input  logic                i_clk_sys,
  input  logic                i_reset,
  input  logic                i_ce_sample,
  input  logic                i_mute,
  input  logic [7:0]          i_audio_1,
  input  logic [7:0]          i_audio_2,
  input  logic [SAMPLE_W-1:0] i_speech,
  input  logic [SAMPLE_W-1:0] i_ym2151_left,
  input  logic [SAMPLE_W-1:0] i_ym2151_right,
  input  logic [GAIN_W-1:0]   i_gain_dac,
  input  logic [GAIN_W-1:0]   i_gain_speech,
  input  logic [GAIN_W-1:0]   i_gain_fm,
  input  logic                i_clr_flags,
  output logic [SAMPLE_W-1:0] o_audio_l,
  output logic [SAMPLE_W-1:0] o_audio_r,
  output logic                o_sample_valid,
  output logic                o_busy,
  output logic                o_clip,
  output logic                o_overrun
);

  mix_state_e              r_state;
  logic [7:0]              r_audio_1, r_audio_2;
  logic [SAMPLE_W-1:0]     r_speech, r_ym_l, r_ym_r;
  logic [GAIN_W-1:0]       r_gain_dac, r_gain_speech, r_gain_fm;
  logic                    r_mute;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic [SAMPLE_W-1:0]     r_sat_l, r_sat_r;
  logic [SAMPLE_W-1:0]     r_audio_l, r_audio_r;
  logic                    r_valid, r_busy, r_clip, r_overrun;

  logic signed [TERM_W-1:0] w_term_a1, w_term_a2, w_term_sp, w_term_fm_l, w_term_fm_r;
  logic signed [TERM_W-1:0] w_shared_term, w_add_l, w_add_r;
  logic                     w_accumulating, w_overrun_set, w_clip_set;

  joust2_gain_term #(.KIND(SRC_DAC)) u_term_a1 (
    .i_raw({r_audio_1, 8'h00}), .i_gain(r_gain_dac), .o_term(w_term_a1));
  joust2_gain_term #(.KIND(SRC_DAC)) u_term_a2 (
    .i_raw({r_audio_2, 8'h00}), .i_gain(r_gain_dac), .o_term(w_term_a2));
  joust2_gain_term #(.KIND(SRC_SPEECH)) u_term_sp (
    .i_raw(r_speech), .i_gain(r_gain_speech), .o_term(w_term_sp));
  joust2_gain_term #(.KIND(SRC_FM)) u_term_fm_l (
    .i_raw(r_ym_l), .i_gain(r_gain_fm), .o_term(w_term_fm_l));
  joust2_gain_term #(.KIND(SRC_FM)) u_term_fm_r (
    .i_raw(r_ym_r), .i_gain(r_gain_fm), .o_term(w_term_fm_r));

  // Source select: DAC and speech terms feed both channels; only ACC3 splits to per-channel FM.
  always_comb begin
    w_shared_term = {TERM_W{1'b0}};
    case (r_state)
      ST_ACC0: w_shared_term = w_term_a1;
      ST_ACC1: w_shared_term = w_term_a2;
      ST_ACC2: w_shared_term = w_term_sp;
      default: w_shared_term = {TERM_W{1'b0}};
    endcase
    if (r_state == ST_ACC3) begin
      w_add_l = w_term_fm_l;
      w_add_r = w_term_fm_r;
    end else begin
      w_add_l = w_shared_term;
      w_add_r = w_shared_term;
    end
  end

  assign w_accumulating = (r_state == ST_ACC0) || (r_state == ST_ACC1) ||
                          (r_state == ST_ACC2) || (r_state == ST_ACC3);
  assign w_overrun_set  = i_ce_sample && (r_state != ST_IDLE);
  assign w_clip_set     = (r_state == ST_SAT) &&
                          (sample_out_of_range(r_acc_l) || sample_out_of_range(r_acc_r));

  // Mix FSM with snapshot, accumulators, saturation, output and sticky flag registers.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_audio_1     <= 8'h00;
      r_audio_2     <= 8'h00;
      r_speech      <= 16'h0000;
      r_ym_l        <= 16'h0000;
      r_ym_r        <= 16'h0000;
      r_gain_dac    <= 4'd0;
      r_gain_speech <= 4'd0;
      r_gain_fm     <= 4'd0;
      r_mute        <= 1'b0;
      r_acc_l       <= 20'sd0;
      r_acc_r       <= 20'sd0;
      r_sat_l       <= 16'h0000;
      r_sat_r       <= 16'h0000;
      r_audio_l     <= 16'h0000;
      r_audio_r     <= 16'h0000;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_clip        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // Set events take priority over a simultaneous clear.
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (i_clr_flags) begin
        r_overrun <= 1'b0;
      end
      if (w_clip_set) begin
        r_clip <= 1'b1;
      end else if (i_clr_flags) begin
        r_clip <= 1'b0;
      end

      if (w_accumulating) begin
        r_acc_l <= r_acc_l + {{(ACC_W-TERM_W){w_add_l[TERM_W-1]}}, w_add_l};
        r_acc_r <= r_acc_r + {{(ACC_W-TERM_W){w_add_r[TERM_W-1]}}, w_add_r};
      end

      case (r_state)
        ST_IDLE: begin
          if (i_ce_sample) begin
            r_audio_1     <= i_audio_1;
            r_audio_2     <= i_audio_2;
            r_speech      <= i_speech;
            r_ym_l        <= i_ym2151_left;
            r_ym_r        <= i_ym2151_right;
            r_gain_dac    <= i_gain_dac;
            r_gain_speech <= i_gain_speech;
            r_gain_fm     <= i_gain_fm;
            r_mute        <= i_mute;
            r_acc_l       <= 20'sd0;
            r_acc_r       <= 20'sd0;
            r_busy        <= 1'b1;
            r_state       <= ST_ACC0;
          end
        end
        ST_ACC0: r_state <= ST_ACC1;
        ST_ACC1: r_state <= ST_ACC2;
        ST_ACC2: r_state <= ST_ACC3;
        ST_ACC3: r_state <= ST_SAT;
        ST_SAT: begin
          r_sat_l <= clamp_sample(r_acc_l);
          r_sat_r <= clamp_sample(r_acc_r);
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_audio_l <= r_mute ? 16'h0000 : r_sat_l;
          r_audio_r <= r_mute ? 16'h0000 : r_sat_r;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_audio_l      = r_audio_l;
  assign o_audio_r      = r_audio_r;
  assign o_sample_valid = r_valid;
  assign o_busy         = r_busy;
  assign o_clip         = r_clip;
  assign o_overrun      = r_overrun;

endmodule
